stopwatch_display_mux: RTL and testbench



---
 rtl/stopwatch_disp_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 11 +
 rtl/stopwatch_display_mux.sv | 179 +++++++++++++++++
 tb/tb_stopwatch_display_mux.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_disp_pkg.sv
// Shared types, constants and the BCD-to-segment map for the stopwatch display mux.
package stopwatch_disp_pkg;

    typedef enum logic [1:0] {SNAP, ON, BLANK} disp_state_t;

    localparam int NUM_DIGITS = 6;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-high 7-segment pattern; non-BCD nibbles show a dash.
module seg7_decoder
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] nibble_in,
    output logic [6:0] seg_out
);

    assign seg_out = bcd_to_seg(nibble_in);

endmodule

// File: rtl/stopwatch_display_mux.sv
// Six-digit multiplexed 7-segment driver: per-frame snapshot, inter-digit blanking,
// leading-zero suppression, decimal points and brightness PWM. All outputs registered.
module stopwatch_display_mux
    import stopwatch_disp_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int DIGIT_TIME_US = 1000,
    parameter int BLANK_CYCLES  = 500,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_data_in,
    input  logic [5:0]  dp_mask_in,
    input  logic        blank_lz_in,
    input  logic [3:0]  brightness_in,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [5:0]  an_out,
    output logic        frame_tick_out
);

    localparam int DIGIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * DIGIT_TIME_US;
    localparam int ON_CYCLES    = DIGIT_CYCLES - BLANK_CYCLES;
    localparam int CNT_W        = $clog2(DIGIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

    // XOR with the off level turns an active-high pattern into pin levels.
    localparam logic       OFF_LVL = (ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_POL = {7{OFF_LVL}};
    localparam logic [5:0] AN_OFF  = {6{OFF_LVL}};

    disp_state_t      state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [3:0]       pwm_q, pwm_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       an_q, an_d;
    logic             tick_q, tick_d;

    logic [23:0]      snap_bcd_q, snap_bcd_d;
    logic [5:0]       snap_dp_q, snap_dp_d;
    logic             snap_lz_q, snap_lz_d;

    // Padded to 8 entries so a 3-bit index never falls outside the vector.
    logic [7:0][3:0]  nibs;
    logic [7:0]       dp_ext;
    logic [7:0]       supp;
    logic [2:0]       next_idx;
    logic [3:0]       dec_nib;
    logic [6:0]       dec_pat;
    logic [4:0]       duty;

    assign nibs     = {8'h00, snap_bcd_q};
    assign dp_ext   = {2'b00, snap_dp_q};
    assign next_idx = idx_q + 3'd1;
    assign duty     = {1'b0, brightness_in} + 5'd1;

    // A zero only hides if every more-significant digit is hidden as well.
    always_comb begin
        supp    = '0;
        supp[5] = snap_lz_q && (nibs[5] == 4'd0);
        supp[4] = supp[5] && (nibs[4] == 4'd0);
        supp[3] = supp[4] && (nibs[3] == 4'd0);
    end

    always_comb begin
        dec_nib = (state_q == SNAP) ? bcd_data_in[3:0] : nibs[next_idx];
    end

    seg7_decoder u_dec (
        .nibble_in (dec_nib),
        .seg_out   (dec_pat)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_d     = slot_q;
        pwm_d      = pwm_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        an_d       = AN_OFF;
        tick_d     = 1'b0;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        case (state_q)
            SNAP: begin
                snap_bcd_d = bcd_data_in;
                snap_dp_d  = dp_mask_in;
                snap_lz_d  = blank_lz_in;
                tick_d     = 1'b1;
                seg_d      = dec_pat ^ SEG_POL;
                dp_d       = dp_mask_in[0] ^ OFF_LVL;
                idx_d      = '0;
                slot_d     = '0;
                pwm_d      = '0;
                state_d    = ON;
            end
            ON: begin
                if (!supp[idx_q] && ({1'b0, pwm_q} < duty))
                    an_d = AN_OFF ^ (6'd1 << idx_q);
                pwm_d = pwm_q + 4'd1;
                if (slot_q == ON_LAST) begin
                    slot_d  = '0;
                    state_d = BLANK;
                end else begin
                    slot_d = slot_q + CNT_ONE;
                end
            end
            BLANK: begin
                // Segments change only while every anode is dark.
                if (slot_q == '0) begin
                    if (idx_q == LAST_IDX || supp[next_idx]) begin
                        seg_d = SEG_OFF ^ SEG_POL;
                        dp_d  = OFF_LVL;
                    end else begin
                        seg_d = dec_pat ^ SEG_POL;
                        dp_d  = dp_ext[next_idx] ^ OFF_LVL;
                    end
                end
                if (slot_q == BLANK_LAST) begin
                    slot_d = '0;
                    pwm_d  = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = SNAP;
                    end else begin
                        idx_d   = next_idx;
                        state_d = ON;
                    end
                end else begin
                    slot_d = slot_q + CNT_ONE;
                end
            end
            default: state_d = SNAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SNAP;
            idx_q   <= '0;
            slot_q  <= '0;
            pwm_q   <= '0;
            seg_q   <= SEG_OFF ^ SEG_POL;
            dp_q    <= OFF_LVL;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    // Snapshot is pure data; the first state after reset always reloads it.
    always_ff @(posedge clk) begin
        snap_bcd_q <= snap_bcd_d;
        snap_dp_q  <= snap_dp_d;
        snap_lz_q  <= snap_lz_d;
    end

    assign seg_out        = seg_q;
    assign dp_out         = dp_q;
    assign an_out         = an_q;
    assign frame_tick_out = tick_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Bench for stopwatch_display_mux: frame-position reference model checked every cycle,
// directed literal scenarios, then randomized inputs with occasional resets.
module tb_stopwatch_display_mux;

    localparam int FRAME = 61;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd_data_in;
    logic [5:0]  dp_mask_in;
    logic        blank_lz_in;
    logic [3:0]  brightness_in;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [5:0]  an_out;
    logic        frame_tick_out;

    int errors = 0;
    int checks = 0;

    stopwatch_display_mux #(
        .CLK_FREQ_HZ   (1_000_000),
        .DIGIT_TIME_US (10),
        .BLANK_CYCLES  (2),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bcd_data_in    (bcd_data_in),
        .dp_mask_in     (dp_mask_in),
        .blank_lz_in    (blank_lz_in),
        .brightness_in  (brightness_in),
        .seg_out        (seg_out),
        .dp_out         (dp_out),
        .an_out         (an_out),
        .frame_tick_out (frame_tick_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    int          pos = 0;
    int          cur_pos = -1;
    logic [23:0] m_bcd = '0;
    logic [5:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    bit          m_supp [6];
    logic [5:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_tick;
    bit          chk_seg;

    function automatic bit hidden(input logic [23:0] b, input logic lz, input int k);
        bit h;
        h = lz && (k >= 3);
        for (int j = k; j < 6; j++)
            if (b[4*j +: 4] != 4'd0) h = 0;
        return h;
    endfunction

    task automatic shown(input int d);
        if (m_supp[d]) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_seg = ~seg_tab[m_bcd[4*d +: 4]];
            e_dp  = ~m_dp[d];
        end
    endtask

    always begin
        int d, r;
        @(posedge clk);
        chk_seg = 1;
        e_tick  = 1'b0;
        e_an    = 6'h3F;
        if (rst) begin
            pos     = 0;
            cur_pos = -1;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
        end else begin
            cur_pos = pos;
            if (pos == 0) begin
                m_bcd = bcd_data_in;
                m_dp  = dp_mask_in;
                m_lz  = blank_lz_in;
                for (int k = 0; k < 6; k++) m_supp[k] = hidden(m_bcd, m_lz, k);
                e_tick = 1'b1;
                shown(0);
            end else begin
                d = (pos - 1) / 10;
                r = (pos - 1) % 10;
                if (r < 8) begin
                    if (!m_supp[d] && r < int'(brightness_in) + 1) e_an[d] = 1'b0;
                    shown(d);
                end else if (d < 5) begin
                    shown(d + 1);
                end else begin
                    chk_seg = 0;
                end
            end
            pos = (pos + 1) % FRAME;
        end
        #1;
        check("an", {26'd0, an_out}, {26'd0, e_an});
        check("tick", {31'd0, frame_tick_out}, {31'd0, e_tick});
        if (chk_seg) begin
            check("seg", {25'd0, seg_out}, {25'd0, e_seg});
            check("dp", {31'd0, dp_out}, {31'd0, e_dp});
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (cur_pos != p && n < 200);
        if (cur_pos != p) begin
            checks++;
            errors++;
            $display("FAIL wait_pos: reached %0d required %0d", cur_pos, p);
        end
    endtask

    task automatic set_in(input logic [23:0] b, input logic [5:0] dpm, input logic lz, input logic [3:0] br);
        @(negedge clk);
        bcd_data_in   = b;
        dp_mask_in    = dpm;
        blank_lz_in   = lz;
        brightness_in = br;
    endtask

    logic [6:0] exp2 [5] = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        int n;
        rst = 1'b1;
        bcd_data_in = '0;
        dp_mask_in = '0;
        blank_lz_in = 1'b0;
        brightness_in = 4'd15;
        repeat (3) @(posedge clk);
        #2;
        check("rst_an", {26'd0, an_out}, 32'h3F);
        check("rst_seg", {25'd0, seg_out}, 32'h7F);
        check("rst_dp", {31'd0, dp_out}, 32'h1);
        check("rst_tick", {31'd0, frame_tick_out}, 32'h0);

        // 1: first frame timing
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("first_tick", {31'd0, frame_tick_out}, 32'h1);
        for (int c = 2; c <= 11; c++) begin
            @(posedge clk);
            #2;
            check("first_an", {26'd0, an_out}, (c <= 9) ? 32'h3E : 32'h3F);
        end
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (frame_tick_out !== 1'b1 && n < 200);
        check("frame_period", 10 + n, FRAME);

        // 2: leading-zero suppression of digit 5 only
        set_in(24'h012345, 6'd0, 1'b1, 4'd15);
        wait_pos(0);
        for (int d = 0; d < 6; d++) begin
            wait_pos(1 + 10 * d);
            if (d < 5) check("t2_seg", {25'd0, seg_out}, {25'd0, exp2[d]});
            else check("t2_d5_dark", {26'd0, an_out}, 32'h3F);
        end

        // 3: three dark digits, dp on digit 2
        set_in(24'h000007, 6'b000100, 1'b1, 4'd15);
        wait_pos(0);
        wait_pos(1);
        check("t3_d0_seg", {25'd0, seg_out}, 32'h78);
        check("t3_d0_dp", {31'd0, dp_out}, 32'h1);
        wait_pos(11);
        check("t3_d1_seg", {25'd0, seg_out}, 32'h40);
        check("t3_d1_dp", {31'd0, dp_out}, 32'h1);
        wait_pos(21);
        check("t3_d2_seg", {25'd0, seg_out}, 32'h40);
        check("t3_d2_dp", {31'd0, dp_out}, 32'h0);
        for (int d = 3; d < 6; d++) begin
            wait_pos(1 + 10 * d);
            check("t3_dark", {26'd0, an_out}, 32'h3F);
        end

        // 4: tear-free snapshot
        set_in(24'h000001, 6'd0, 1'b0, 4'd15);
        wait_pos(0);
        wait_pos(1);
        check("t4_old_d0", {25'd0, seg_out}, 32'h79);
        wait_pos(31);
        @(negedge clk);
        bcd_data_in = 24'h090009;
        wait_pos(41);
        check("t4_old_d4", {25'd0, seg_out}, 32'h40);
        wait_pos(0);
        wait_pos(1);
        check("t4_new_d0", {25'd0, seg_out}, 32'h10);

        // 5: brightness 3 and a dash
        set_in(24'h00000A, 6'd0, 1'b0, 4'd3);
        wait_pos(0);
        for (int r = 0; r < 8; r++) begin
            wait_pos(1 + r);
            check("t5_pwm_an0", {31'd0, an_out[0]}, (r < 4) ? 32'h0 : 32'h1);
            if (r == 0) check("t5_dash", {25'd0, seg_out}, 32'h3F);
        end

        // 6: asynchronous reset mid-frame
        wait_pos(21);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_an", {26'd0, an_out}, 32'h3F);
        check("t6_seg", {25'd0, seg_out}, 32'h7F);
        check("t6_dp", {31'd0, dp_out}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("t6_restart_tick", {31'd0, frame_tick_out}, 32'h1);

        // random phase, model checks every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 6; k++)
                    bcd_data_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_mask_in  = 6'($urandom_range(0, 63));
                blank_lz_in = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) brightness_in = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule
